// File: rtl/jtbubl_irqctl.sv
// Multi-channel interrupt controller with mode-2 vector generation and an optional
// lvbl-based watchdog (enable with `define JTBUBL_IRQCTL_WDOG_EN).
module jtbubl_irqctl #(
  parameter int         CH      = 4,
  parameter logic [7:0] VEC_RST = 8'h2e,
  parameter int         WDOG_W  = 8,
  parameter int         RSTLEN  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic [CH-1:0] irq_src,
  input  logic          cs,
  input  logic          wr,
  input  logic [1:0]    addr,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  input  logic          iack,
  output logic          int_n,
  output logic [7:0]    vector,
  input  logic          lvbl,
  output logic          wdog_rst
);

  localparam int IW = (CH > 1) ? $clog2(CH) : 1;

  logic [CH-1:0] mask;
  logic [CH-1:0] pending;
  logic [CH-1:0] last_src;
  logic [7:0]    base;
  logic          last_iack;

  logic [CH-1:0] req;
  logic          any_req;
  logic [IW-1:0] idx;
  logic [7:0]    off;
  logic          iack_rise;
  logic          reg_wr;
  logic [CH-1:0] src_rise;
  logic [CH-1:0] ack_clr;
  logic [CH-1:0] wr_clr;
  logic [7:0]    wd_rd;

  assign req       = pending & mask;
  assign any_req   = |req;
  assign iack_rise = iack & ~last_iack;
  assign reg_wr    = cs & wr;
  assign src_rise  = cen ? (irq_src & ~last_src) : '0;
  assign wr_clr    = (reg_wr && addr == 2'd1) ? din[CH-1:0] : '0;

  // Scan downwards so the lowest requesting index is the one left in idx.
  always_comb begin
    idx = '0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

  always_comb begin
    off        = '0;
    off[IW:0]  = {idx, 1'b0};
    ack_clr    = '0;
    if (iack_rise && any_req) ack_clr[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask      <= '1;
      pending   <= '0;
      last_src  <= '1;
      base      <= VEC_RST;
      vector    <= VEC_RST;
      int_n     <= 1'b1;
      last_iack <= 1'b0;
    end else begin
      last_iack <= iack;
      if (cen) last_src <= irq_src;
      // A new edge overrides any clear aimed at the same bit this cycle.
      pending   <= (pending & ~ack_clr & ~wr_clr) | src_rise;
      int_n     <= ~any_req;
      if (iack_rise) vector <= any_req ? base + off : 8'hff;
      if (reg_wr && addr == 2'd0) mask <= din[CH-1:0];
      if (reg_wr && addr == 2'd2) base <= din;
    end
  end

  always_comb begin
    dout = '0;
    case (addr)
      2'd0:    dout[CH-1:0] = mask;
      2'd1:    dout[CH-1:0] = pending;
      2'd2:    dout = base;
      default: dout = wd_rd;
    endcase
  end

`ifdef JTBUBL_IRQCTL_WDOG_EN
  localparam int PW = (RSTLEN > 1) ? $clog2(RSTLEN) : 1;
  localparam int RW = (WDOG_W < 8) ? WDOG_W : 8;

  logic [WDOG_W-1:0] wd_cnt;
  logic [PW-1:0]     pulse_cnt;
  logic              last_lvbl;
  logic              wd_active;
  logic              kick;
  logic              lvbl_rise;

  assign kick      = reg_wr & (addr == 2'd3);
  assign lvbl_rise = lvbl & ~last_lvbl;
  assign wdog_rst  = wd_active;

  always_comb begin
    wd_rd         = '0;
    wd_rd[RW-1:0] = wd_cnt[RW-1:0];
  end

  // Counting stops once the top bit is reached; the pulse then runs its full
  // length regardless of kicks, and the count is zeroed as it ends.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt    <= '0;
      pulse_cnt <= '0;
      last_lvbl <= 1'b1;
      wd_active <= 1'b0;
    end else begin
      last_lvbl <= lvbl;
      if (wd_active) begin
        if (pulse_cnt == '0) begin
          wd_active <= 1'b0;
          wd_cnt    <= '0;
        end else begin
          pulse_cnt <= pulse_cnt - PW'(1);
          if (kick) wd_cnt <= '0;
        end
      end else begin
        if (wd_cnt[WDOG_W-1]) begin
          wd_active <= 1'b1;
          pulse_cnt <= PW'(RSTLEN - 1);
        end
        if (kick) wd_cnt <= '0;
        else if (lvbl_rise && !wd_cnt[WDOG_W-1]) wd_cnt <= wd_cnt + WDOG_W'(1);
      end
    end
  end
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, lvbl};
  assign wd_rd     = 8'h00;
  assign wdog_rst  = 1'b0;
`endif

endmodule

// File: tb/tb_jtbubl_irqctl.sv
// Randomised and directed bench for jtbubl_irqctl against an integer/array-level
// reference model of the interrupt controller and watchdog.
module tb_jtbubl_irqctl;
  localparam int CH = 4;
  localparam int WW = 3;
  localparam int RL = 16;

  logic          clk = 1'b0;
  logic          rst_n, cen, cs, wr, iack, lvbl;
  logic [CH-1:0] irq_src;
  logic [1:0]    addr;
  logic [7:0]    din, dout, vector;
  logic          int_n, wdog_rst;

  always #5 clk = ~clk;

  jtbubl_irqctl #(.CH(CH), .VEC_RST(8'h2e), .WDOG_W(WW), .RSTLEN(RL)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .irq_src(irq_src), .cs(cs), .wr(wr),
    .addr(addr), .din(din), .dout(dout), .iack(iack), .int_n(int_n),
    .vector(vector), .lvbl(lvbl), .wdog_rst(wdog_rst)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit m_mask[CH], m_pend[CH], m_hist[CH];
  int m_base, m_vec, m_cnt, m_left;
  bit m_intn, m_iack_h, m_lvbl_h;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_read(int a);
    int v = 0;
    case (a)
      0: for (int i = 0; i < CH; i++) v += m_mask[i] ? (1 << i) : 0;
      1: for (int i = 0; i < CH; i++) v += m_pend[i] ? (1 << i) : 0;
      2: v = m_base;
`ifdef JTBUBL_IRQCTL_WDOG_EN
      default: v = m_cnt;
`else
      default: v = 0;
`endif
    endcase
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < CH; i++) begin
      m_mask[i] = 1; m_pend[i] = 0; m_hist[i] = 1;
    end
    m_base = 'h2e; m_vec = 'h2e; m_intn = 1;
    m_iack_h = 0; m_lvbl_h = 1; m_cnt = 0; m_left = 0;
  endtask

  task automatic m_clock();
    int  win;
    bit  rise, set, clr, kick, lrise;
    if (!rst_n) begin
      m_reset();
      return;
    end
    win = -1;
    for (int i = 0; i < CH; i++) if (win < 0 && m_pend[i] && m_mask[i]) win = i;
    rise = iack && !m_iack_h;
    if (rise) m_vec = (win >= 0) ? (m_base + 2 * win) % 256 : 255;
    for (int i = 0; i < CH; i++) begin
      set = cen && irq_src[i] && !m_hist[i];
      clr = (rise && win == i) || (cs && wr && addr == 1 && din[i]);
      m_pend[i] = set || (m_pend[i] && !clr);
      if (cen) m_hist[i] = irq_src[i];
      if (cs && wr && addr == 0) m_mask[i] = din[i];
    end
    if (cs && wr && addr == 2) m_base = din;
    m_intn   = (win < 0);
    m_iack_h = iack;
    kick  = cs && wr && addr == 3;
    lrise = lvbl && !m_lvbl_h;
`ifdef JTBUBL_IRQCTL_WDOG_EN
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 || kick) m_cnt = 0;
    end else if (m_cnt >= (1 << (WW - 1))) begin
      m_left = RL;
      if (kick) m_cnt = 0;
    end else if (kick) m_cnt = 0;
    else if (lrise) m_cnt++;
`else
    if (kick && lrise) m_cnt = 0;
`endif
    m_lvbl_h = lvbl;
  endtask

  // One clock: check dout for the inputs just driven, clock the DUT and model,
  // then compare registered outputs on the falling edge.
  task automatic step();
    #1;
    check("dout", dout, m_read(addr));
    @(posedge clk);
    m_clock();
    @(negedge clk);
    check("int_n", int_n, m_intn);
    check("vector", vector, m_vec);
    check("wdog_rst", wdog_rst, (m_left > 0));
  endtask

  task automatic wr_reg(int a, int d);
    cs = 1; wr = 1; addr = 2'(a); din = 8'(d);
    step();
    cs = 0; wr = 0; addr = 0; din = 0;
  endtask

  task automatic rd_chk(string name, int a, int exp);
    cs = 1; wr = 0; addr = 2'(a);
    #1;
    check(name, dout, exp);
    check({name, "_model"}, m_read(a), exp);
    cs = 0; addr = 0;
  endtask

  task automatic lvbl_edge();
    lvbl = 1; step();
    lvbl = 0; step();
  endtask

  initial begin
    int seen, cnt;
    rst_n = 0; cen = 1; cs = 0; wr = 0; iack = 0; lvbl = 0;
    irq_src = '0; addr = 0; din = 0;
    repeat (3) @(posedge clk);
    m_reset();
    @(negedge clk);
    check("rst_int_n", int_n, 1);
    check("rst_vector", vector, 8'h2e);
    check("rst_wdog", wdog_rst, 0);
    rd_chk("rst_mask", 0, 'h0f);
    rd_chk("rst_pend", 1, 0);
    rd_chk("rst_base", 2, 'h2e);
    rst_n = 1;
    step();

    // Single channel round trip
    irq_src = 4'b0001; step();
    check("t1_int_n_lat", int_n, 1);
    step();
    check("t1_int_n", int_n, 0);
    iack = 1; step();
    check("t1_vector", vector, 8'h2e);
    iack = 0; step();
    check("t1_int_n_clr", int_n, 1);
    rd_chk("t1_pend", 1, 0);
    irq_src = 0; step();

    // Priority with a programmed base
    wr_reg(2, 'h40);
    irq_src = 4'b0110; step();
    irq_src = 0; step();
    iack = 1; step();
    check("t2_vec_a", vector, 8'h42);
    iack = 0; step();
    iack = 1; step();
    check("t2_vec_b", vector, 8'h44);
    iack = 0; step();
    step();
    check("t2_int_n", int_n, 1);

    // Masked pending stays latched
    wr_reg(0, 'h0e);
    irq_src = 4'b0001; step();
    irq_src = 0; step(); step();
    check("t3_masked", int_n, 1);
    rd_chk("t3_pend", 1, 'h01);
    wr_reg(0, 'h0f);
    step();
    check("t3_unmask", int_n, 0);
    wr_reg(1, 'h0f);
    step();

    // Spurious ack, and set beating a same-cycle clear
    iack = 1; step();
    check("t4_spurious", vector, 8'hff);
    iack = 0; step();
    rd_chk("t4_pend", 1, 0);
    cs = 1; wr = 1; addr = 1; din = 8'h02; irq_src = 4'b0010;
    step();
    cs = 0; wr = 0; addr = 0; din = 0;
    rd_chk("t4_set_wins", 1, 'h02);
    irq_src = 0;
    wr_reg(1, 'hff);

`ifdef JTBUBL_IRQCTL_WDOG_EN
    wr_reg(3, 0);
    repeat (4) lvbl_edge();
    check("t5_wdog_on", wdog_rst, 1);
    cnt = 1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (wdog_rst) cnt++;
      else break;
    end
    check("t5_pulse_len", cnt, RL);
    rd_chk("t5_cnt_zero", 3, 0);
    seen = 0;
    for (int r = 0; r < 4; r++) begin
      repeat (3) begin
        lvbl_edge();
        if (wdog_rst) seen++;
      end
      wr_reg(3, 'h5a);
    end
    check("t5_kicked", seen, 0);
`else
    seen = 0;
    repeat (300) begin
      lvbl_edge();
      if (wdog_rst) seen++;
    end
    check("t6_no_wdog", seen, 0);
    wr_reg(3, 'hff);
    rd_chk("t6_addr3", 3, 0);
`endif

    // Randomised traffic
    for (int n = 0; n < 4000; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      cen   = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) irq_src = CH'($urandom);
      if ($urandom_range(0, 2) == 0) iack = ~iack;
      if ($urandom_range(0, 2) == 0) lvbl = ~lvbl;
      cs   = ($urandom_range(0, 3) == 0);
      wr   = $urandom_range(0, 1);
      addr = 2'($urandom_range(0, 3));
      din  = 8'($urandom);
      if (cs && wr && addr == 0 && $urandom_range(0, 1) == 1) din[3:0] = 4'hf;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
